// File: rtl/inst_fetch_unit.sv
// PC generation and fetch sequencing front end: issues 128-bit imem line reads,
// tracks the one-cycle read latency and presents per-slot valid/PC downstream.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IMEM_ADDR_WIDTH = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_stall,
  input  logic                       i_redirect_vld,
  input  logic [31:0]                i_redirect_pc,
  output logic                       o_imem_rd_en,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_rd_addr,
  output logic [1:0]                 o_sel,
  output logic                       o_inst_vld_1,
  output logic                       o_inst_vld_2,
  output logic [31:0]                o_pc_1,
  output logic [31:0]                o_pc_2,
  output logic                       o_misalign_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] f1_pc;
  logic        f1_vld;
  logic [31:0] pc_step;
  logic [31:0] redirect_target;
  logic        redirect_misaligned;

  // An odd slot fetches a single instruction so the next fetch lands on a pair boundary.
  assign pc_step             = pc_q[2] ? 32'd4 : 32'd8;
  assign redirect_target     = {i_redirect_pc[31:2], 2'b00};
  assign redirect_misaligned = |i_redirect_pc[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      f1_pc          <= RESET_PC;
      f1_vld         <= 1'b0;
      o_misalign_err <= 1'b0;
    end else begin
      o_misalign_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // Redirect beats stall and kills whatever line is currently in flight.
          if (i_redirect_vld) begin
            pc_q           <= redirect_target;
            f1_vld         <= 1'b0;
            o_misalign_err <= redirect_misaligned;
          end else if (!i_stall) begin
            f1_pc  <= pc_q;
            f1_vld <= 1'b1;
            pc_q   <= pc_q + pc_step;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_imem_rd_en   = (state_q == RUN) && (!i_stall || i_redirect_vld);
  assign o_imem_rd_addr = pc_q[IMEM_ADDR_WIDTH+3:4];
  assign o_sel          = f1_pc[3:2];
  assign o_inst_vld_1   = f1_vld;
  assign o_inst_vld_2   = f1_vld & ~f1_pc[2];
  assign o_pc_1         = f1_pc;
  assign o_pc_2         = f1_pc + 32'd4;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed walk through the fetch
// scenarios followed by a randomized run against a fetch-stream reference model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          AW       = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stall;
  logic          redir;
  logic [31:0]   redir_pc;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    sel;
  logic          vld_1;
  logic          vld_2;
  logic [31:0]   pc_1;
  logic [31:0]   pc_2;
  logic          mis_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: "fetching" flag, the next PC to fetch, and the fetch
  // whose data is being presented (or none).
  bit          m_fetching;
  logic [31:0] m_next_pc;
  bit          m_have_fetch;
  logic [31:0] m_fetch_pc;
  bit          m_err;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_ADDR_WIDTH(AW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_stall        (stall),
    .i_redirect_vld (redir),
    .i_redirect_pc  (redir_pc),
    .o_imem_rd_en   (rd_en),
    .o_imem_rd_addr (rd_addr),
    .o_sel          (sel),
    .o_inst_vld_1   (vld_1),
    .o_inst_vld_2   (vld_2),
    .o_pc_1         (pc_1),
    .o_pc_2         (pc_2),
    .o_misalign_err (mis_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Expected outputs derived from the fetch being presented this cycle.
  task automatic check_model();
    logic [31:0] line_addr;
    bit          two_wide;
    line_addr = m_next_pc >> 4;
    two_wide  = m_have_fetch && (m_fetch_pc % 8 == 0);
    chk("vld_1",   32'(vld_1),   32'(m_have_fetch));
    chk("vld_2",   32'(vld_2),   32'(two_wide));
    chk("pc_1",    pc_1,         m_fetch_pc);
    chk("pc_2",    pc_2,         m_fetch_pc + 32'd4);
    chk("sel",     32'(sel),     (m_fetch_pc / 4) % 4);
    chk("rd_en",   32'(rd_en),   32'(m_fetching && (!stall || redir)));
    chk("rd_addr", 32'(rd_addr), line_addr % (1 << AW));
    chk("mis_err", 32'(mis_err), 32'(m_err));
  endtask

  task automatic model_clock();
    if (rst) begin
      m_fetching   = 0;
      m_next_pc    = RESET_PC;
      m_have_fetch = 0;
      m_fetch_pc   = RESET_PC;
      m_err        = 0;
    end else if (!m_fetching) begin
      m_err = 0;
      if (start) m_fetching = 1;
    end else begin
      m_err = 0;
      if (redir) begin
        m_next_pc    = redir_pc - (redir_pc % 4);
        m_have_fetch = 0;
        m_err        = (redir_pc % 4) != 0;
      end else if (!stall) begin
        m_fetch_pc   = m_next_pc;
        m_have_fetch = 1;
        // Fetch up to the end of the current 8-byte instruction pair.
        m_next_pc    = m_next_pc + (8 - (m_next_pc % 8));
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit st, input bit rd, input logic [31:0] rpc);
    rst = r; start = s; stall = st; redir = rd; redir_pc = rpc;
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = '0;
    m_fetching = 0; m_next_pc = RESET_PC; m_have_fetch = 0; m_fetch_pc = RESET_PC; m_err = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    chk("reset_vld_1", 32'(vld_1), 32'd0);
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    chk("reset_sel",   32'(sel),   32'(RESET_PC[3:2]));

    // Start, then free-running fetch
    step(0, 1, 0, 0, 0);
    chk("tp_c1_rd_addr", 32'(rd_addr), 32'd0);
    chk("tp_c1_vld_1",   32'(vld_1),   32'd0);
    step(0, 0, 0, 0, 0);
    chk("tp_c2_pc_1",  pc_1,        32'h0);
    chk("tp_c2_pc_2",  pc_2,        32'h4);
    chk("tp_c2_vld_2", 32'(vld_2),  32'd1);
    step(0, 0, 0, 0, 0);
    chk("tp_c3_sel",  32'(sel), 32'd2);
    chk("tp_c3_pc_1", pc_1,     32'h8);
    step(0, 0, 0, 0, 0);
    chk("tp_c4_pc_1",    pc_1,         32'h10);
    chk("tp_c4_rd_addr", 32'(rd_addr), 32'd1);

    // Stall for three cycles holds outputs
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      chk("stall_pc_1", pc_1,     32'h10);
      chk("stall_sel",  32'(sel), 32'd0);
    end
    step(0, 0, 0, 0, 0);
    chk("stall_release_pc_1", pc_1, 32'h18);

    // Redirect to an odd slot
    step(0, 0, 0, 1, 32'h24);
    chk("redir_kill_vld_1", 32'(vld_1), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("redir_pc_1",  pc_1,        32'h24);
    chk("redir_sel",   32'(sel),    32'd1);
    chk("redir_vld_2", 32'(vld_2),  32'd0);
    step(0, 0, 0, 0, 0);
    chk("redir_next_pc_1",  pc_1,       32'h28);
    chk("redir_next_vld_2", 32'(vld_2), 32'd1);

    // Redirect wins over a simultaneous stall
    step(0, 0, 1, 1, 32'h40);
    chk("stall_redir_vld_1", 32'(vld_1), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("stall_redir_pc_1", pc_1, 32'h40);

    // Misaligned redirect
    step(0, 0, 0, 1, 32'h102);
    chk("misalign_pulse", 32'(mis_err), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("misalign_clear", 32'(mis_err), 32'd0);
    chk("misalign_pc_1",  pc_1,         32'h100);

    // Wraparound at the top of the address space
    step(0, 0, 0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 0);
    chk("wrap_pc_1_top", pc_1, 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 0);
    chk("wrap_pc_1_zero", pc_1, 32'h0);

    // Reset mid-run, then stall/redirect ignored while idle
    step(1, 0, 0, 0, 0);
    chk("midreset_vld_1", 32'(vld_1), 32'd0);
    step(0, 0, 0, 1, 32'h80);
    step(0, 0, 0, 0, 0);
    chk("idle_ignore_vld_1", 32'(vld_1), 32'd0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("restart_pc_1", pc_1, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit          r, s, st, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 40);
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 10);
      rpc = $urandom();
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step(r, s, st, rd, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
